// File: rtl/wr_en_sync_fifo.sv
// Synchronous FIFO fed by the wr/en strobe pair, with a registered 1-cycle read port and sticky error flags.
// Optional WR_EN_EDGE_QUAL_EN: accept one push per contiguous wr&en-high interval instead of one per cycle.
module wr_en_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_req;
  logic              pop_req;
  logic              push_acc;
  logic              pop_acc;

`ifdef WR_EN_EDGE_QUAL_EN
  logic wr_q;
  logic en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= 1'b0;
      en_q <= 1'b0;
    end else begin
      wr_q <= wr;
      en_q <= en;
    end
  end

  assign push_req = (wr & en) & ~(wr_q & en_q);
`else
  assign push_req = wr & en;
`endif

  assign pop_req  = rd;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_acc  = pop_req & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign push_acc = push_req & (~full | pop_acc);

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      dout_valid <= pop_acc;
      if (pop_acc) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;

      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (clr_err)                   overflow <= 1'b0;
      else if (push_req & ~push_acc) overflow <= 1'b1;

      if (clr_err)                 underflow <= 1'b0;
      else if (pop_req & ~pop_acc) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wr_en_sync_fifo.sv
// Self-checking bench for wr_en_sync_fifo: directed boundary cases plus random traffic against a queue model.
module tb_wr_en_sync_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr = 1'b0;
  logic              en = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              rd = 1'b0;
  logic              clr_err = 1'b0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  wr_en_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr(wr), .en(en), .din(din), .rd(rd), .clr_err(clr_err),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout;
  logic              m_dv;
  logic              m_ovf;
  logic              m_unf;
  logic              m_prev_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_dv = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_prev_we = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic e, input logic [DATA_W-1:0] d,
                            input logic r, input logic c);
    logic preq, pop_ok, push_ok;
`ifdef WR_EN_EDGE_QUAL_EN
    preq = (w & e) & ~m_prev_we;
`else
    preq = w & e;
`endif
    m_prev_we = w & e;
    pop_ok  = r && (q.size() > 0);
    push_ok = preq && ((q.size() < DEPTH) || pop_ok);
    if (pop_ok) begin
      m_dout = q.pop_front();
      m_dv = 1'b1;
    end else begin
      m_dv = 1'b0;
    end
    if (push_ok) q.push_back(d);
    if (c) m_ovf = 1'b0;
    else if (preq && !push_ok) m_ovf = 1'b1;
    if (c) m_unf = 1'b0;
    else if (r && !pop_ok) m_unf = 1'b1;
  endtask

  task automatic compare_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_dv));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // Inputs are driven 1 time unit after a posedge; outputs are sampled 1 unit after the next.
  task automatic cycle(input logic w, input logic e, input logic [DATA_W-1:0] d,
                       input logic r, input logic c);
    wr = w; en = e; din = d; rd = r; clr_err = c;
    @(posedge clk);
    model_step(w, e, d, r, c);
    #1;
    compare_all();
  endtask

  // Single-cycle strobe followed by an idle cycle so both push qualification modes agree.
  task automatic push(input logic [DATA_W-1:0] d);
    cycle(1'b1, 1'b1, d, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input logic [DATA_W-1:0] v);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("pop_dout", 32'(dout), 32'(v));
    chk("pop_valid", 32'(dout_valid), 32'd1);
  endtask

  task automatic fill_1144();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
  endtask

  initial begin
    logic w, e;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    cycle(0, 0, '0, 0, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_dout", 32'(dout), 32'd0);

    // Fill and drain in order
    fill_1144();
    chk("full_after_4", 32'(full), 32'd1);
    pop_expect(8'h11); pop_expect(8'h22); pop_expect(8'h33); pop_expect(8'h44);
    cycle(0, 0, '0, 0, 0);
    chk("empty_after_drain", 32'(empty), 32'd1);
    chk("valid_idle", 32'(dout_valid), 32'd0);
    chk("dout_hold", 32'(dout), 32'h44);

    // Full + push, no pop: dropped, overflow sticky until clr_err
    fill_1144();
    cycle(1, 1, 8'h55, 0, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    cycle(0, 0, '0, 0, 0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    pop_expect(8'h11); pop_expect(8'h22); pop_expect(8'h33); pop_expect(8'h44);
    cycle(0, 0, '0, 0, 1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full + push + pop: both accepted, pointers wrap
    fill_1144();
    cycle(1, 1, 8'h55, 1, 0);
    chk("fpp_count", 32'(count), 32'd4);
    chk("fpp_ovf", 32'(overflow), 32'd0);
    chk("fpp_dout", 32'(dout), 32'h11);
    pop_expect(8'h22); pop_expect(8'h33); pop_expect(8'h44); pop_expect(8'h55);

    // Empty + push + pop: no bypass, underflow
    cycle(1, 1, 8'hA5, 1, 0);
    chk("epp_unf", 32'(underflow), 32'd1);
    chk("epp_count", 32'(count), 32'd1);
    chk("epp_valid", 32'(dout_valid), 32'd0);
    cycle(0, 0, '0, 0, 0);
    pop_expect(8'hA5);
    cycle(0, 0, '0, 0, 1);
    chk("unf_clr", 32'(underflow), 32'd0);

    // clr_err beats a same-cycle underflow
    cycle(0, 0, '0, 1, 1);
    chk("clr_priority", 32'(underflow), 32'd0);

    // Asynchronous reset mid-stream
    push(8'h01); push(8'h02); push(8'h03);
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    model_reset();
    #2 rst = 1'b0;
    cycle(0, 0, '0, 0, 0);
    push(8'hC3);
    pop_expect(8'hC3);

    // wr toggles every 2 cycles, en every 3 cycles
    for (int i = 0; i < 24; i++) begin
      w = ((i / 2) % 2) == 0;
      e = ((i / 3) % 2) == 0;
      cycle(w, e, 8'(8'h60 + i), 1'b0, 1'b0);
    end
    while (q.size() > 0) pop_expect(q[0]);
    cycle(0, 0, '0, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
